// File: rtl/key_ser_pkg.sv
// Shared types and constants for the serial key-load transmitter.
package key_ser_pkg;

  localparam int unsigned KEY_W_DEFAULT = 128;
  localparam logic        START_BIT     = 1'b1;
  localparam logic        IDLE_LEVEL    = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StGap
  } state_e;

endpackage

// File: rtl/key_serializer_if.sv
// Host-side key handshake plus serial line and frame status of key_serializer.
interface key_serializer_if #(
  parameter int unsigned KEY_W = key_ser_pkg::KEY_W_DEFAULT
) ();

  logic [KEY_W-1:0] key_in;
  logic             key_valid;
  logic             key_ready;
  logic             k_out;
  logic             busy;
  logic             done;

  modport master (
    output key_in,
    output key_valid,
    input  key_ready,
    input  k_out,
    input  busy,
    input  done
  );

  modport slave (
    input  key_in,
    input  key_valid,
    output key_ready,
    output k_out,
    output busy,
    output done
  );

endinterface

// File: rtl/key_ser_shift.sv
// Loadable key shift register; head is the next bit to leave, in either direction.
module key_ser_shift #(
  parameter int unsigned KEY_W     = 128,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [KEY_W-1:0] din,
  output logic             head
);

  logic [KEY_W-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= (MSB_FIRST != 0) ? {sr_q[KEY_W-2:0], 1'b0} : {1'b0, sr_q[KEY_W-1:1]};
    end
  end

  assign head = (MSB_FIRST != 0) ? sr_q[KEY_W-1] : sr_q[0];

endmodule

// File: rtl/key_serializer.sv
// Serialises a parallel key into a start/data[/parity]/gap frame on k_out.
// Optional even-parity bit after the data field when KEY_SER_PARITY_EN is defined.
module key_serializer
  import key_ser_pkg::*;
#(
  parameter int unsigned KEY_W      = KEY_W_DEFAULT,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             reset,
  key_serializer_if.slave  bus
);

  localparam int unsigned    CntW    = $clog2(KEY_W);
  localparam logic [CntW-1:0] CntLast = CntW'(KEY_W - 1);
  localparam int unsigned    GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam state_e         AfterTail = (GAP_CYCLES == 0) ? StIdle : StGap;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            k_out_q, k_out_d;
  logic            done_c;
  logic            load, shift, head;
  state_e          after_data;

`ifdef KEY_SER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^bus.key_in;
    end
  end

  assign after_data = StParity;
`else
  assign after_data = AfterTail;
`endif

  assign load  = (state_q == StIdle) && bus.key_valid;
  assign shift = (state_d == StData);

  key_ser_shift #(
    .KEY_W     (KEY_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (bus.key_in),
    .head  (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      k_out_q <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      k_out_q <= k_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_c  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.key_valid) state_d = StStart;
      end
      StStart: begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: begin
        if (cnt_q == CntLast) begin
          state_d = after_data;
          gap_d   = '0;
          done_c  = (after_data == StIdle);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef KEY_SER_PARITY_EN
      StParity: begin
        state_d = AfterTail;
        gap_d   = '0;
        done_c  = (AfterTail == StIdle);
      end
`endif
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
          done_c  = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // k_out is registered, so it is loaded with the level belonging to the next state.
  always_comb begin
    k_out_d = IDLE_LEVEL;
    case (state_d)
      StStart:  k_out_d = START_BIT;
      StData:   k_out_d = head;
`ifdef KEY_SER_PARITY_EN
      StParity: k_out_d = parity_q;
`endif
      default:  k_out_d = IDLE_LEVEL;
    endcase
  end

  assign bus.k_out     = k_out_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.key_ready = (state_q == StIdle);
  assign bus.done      = done_c;

endmodule

// File: tb/tb_key_serializer.sv
// Scoreboard bench: two instances (MSB-first/gap 2 and LSB-first/gap 0) checked frame by frame.
module tb_key_serializer;
  import key_ser_pkg::*;

  localparam int unsigned KW = 128;
`ifdef KEY_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [255:0] bits;
    int           len;
    int           idle;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_serializer_if #(.KEY_W(KW)) bus0 ();
  key_serializer_if #(.KEY_W(KW)) bus1 ();

  key_serializer #(.KEY_W(KW), .GAP_CYCLES(2), .MSB_FIRST(1)) dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0)
  );

  key_serializer #(.KEY_W(KW), .GAP_CYCLES(0), .MSB_FIRST(0)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  logic [KW-1:0] kin [2];
  logic          kval[2];
  logic          rdy [2];
  logic          kout[2];
  logic          bz  [2];
  logic          dn  [2];

  assign bus0.key_in    = kin[0];
  assign bus0.key_valid = kval[0];
  assign bus1.key_in    = kin[1];
  assign bus1.key_valid = kval[1];
  assign rdy[0]  = bus0.key_ready;
  assign rdy[1]  = bus1.key_ready;
  assign kout[0] = bus0.k_out;
  assign kout[1] = bus1.k_out;
  assign bz[0]   = bus0.busy;
  assign bz[1]   = bus1.busy;
  assign dn[0]   = bus0.done;
  assign dn[1]   = bus1.done;

  int gaps[2] = '{2, 0};
  bit msbs[2] = '{1'b1, 1'b0};

  frame_t exp_q[2][$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference frame: start bit, key bits in wire order, optional even parity, gap zeros.
  function automatic frame_t model(logic [KW-1:0] key, bit msb, int gap, int idle);
    frame_t f;
    f.bits    = '0;
    f.bits[0] = 1'b1;
    for (int i = 0; i < KW; i++) f.bits[1+i] = msb ? key[KW-1-i] : key[i];
    f.len = 1 + KW;
    if (PAR_EN) begin
      f.bits[f.len] = ($countones(key) % 2) == 1;
      f.len++;
    end
    f.len += gap;
    f.idle = idle;
    return f;
  endfunction

  function automatic logic [KW-1:0] rnd_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send(int d, logic [KW-1:0] k, int idle_exp);
    int w = 0;
    @(negedge clk);
    while (!rdy[d] && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!rdy[d]) begin
      check($sformatf("dut%0d_ready_timeout", d), 256'(0), 256'(1));
      return;
    end
    exp_q[d].push_back(model(k, msbs[d], gaps[d], idle_exp));
    kin[d]  = k;
    kval[d] = 1'b1;
    @(negedge clk);
    kval[d] = 1'b0;
    kin[d]  = rnd_key();
  endtask

  // key_valid stays high across two frames; key_in is scrambled whenever the DUT is busy.
  task automatic hold_two(int d, logic [KW-1:0] a, logic [KW-1:0] b);
    int sent = 0;
    int cyc  = 0;
    while (sent < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (rdy[d]) begin
        kin[d]  = (sent == 0) ? a : b;
        kval[d] = 1'b1;
        exp_q[d].push_back(model(kin[d], msbs[d], gaps[d], (sent == 0) ? -1 : 1));
        sent++;
      end else begin
        kin[d] = rnd_key();
      end
    end
    @(negedge clk);
    kval[d] = 1'b0;
    if (sent < 2) check($sformatf("dut%0d_hold_timeout", d), 256'(sent), 256'(2));
  endtask

  bit           in_frame  [2];
  logic [255:0] cap       [2];
  int           clen      [2];
  int           dcount    [2];
  bit           dlast     [2];
  int           idle_cnt  [2];
  int           start_idle[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        in_frame[d] = 1'b0;
        idle_cnt[d] = 0;
      end else begin
        check($sformatf("dut%0d_ready_vs_busy", d), 256'(rdy[d]), 256'(!bz[d]));
        if (bz[d]) begin
          if (!in_frame[d]) begin
            in_frame[d]   = 1'b1;
            cap[d]        = '0;
            clen[d]       = 0;
            dcount[d]     = 0;
            start_idle[d] = idle_cnt[d];
          end
          cap[d][clen[d]] = kout[d];
          clen[d]++;
          if (dn[d]) dcount[d]++;
          dlast[d] = dn[d];
        end else begin
          check($sformatf("dut%0d_idle_level", d), 256'(kout[d]), 256'(IDLE_LEVEL));
          check($sformatf("dut%0d_idle_done", d), 256'(dn[d]), 256'(0));
          if (in_frame[d]) begin
            in_frame[d] = 1'b0;
            idle_cnt[d] = 1;
            if (exp_q[d].size() == 0) begin
              check($sformatf("dut%0d_unexpected_frame", d), 256'(1), 256'(0));
            end else begin
              frame_t e;
              e = exp_q[d].pop_front();
              check($sformatf("dut%0d_frame_len", d), 256'(clen[d]), 256'(e.len));
              check($sformatf("dut%0d_frame_bits", d), cap[d], e.bits);
              check($sformatf("dut%0d_done_count", d), 256'(dcount[d]), 256'(1));
              check($sformatf("dut%0d_done_last", d), 256'(dlast[d]), 256'(1));
              if (e.idle >= 0)
                check($sformatf("dut%0d_idle_between", d), 256'(start_idle[d]), 256'(e.idle));
            end
          end else begin
            idle_cnt[d]++;
          end
        end
      end
    end
  end

  initial begin
    logic [KW-1:0] ones;
    int w;
    ones    = '1;
    kin[0]  = '0;
    kin[1]  = '0;
    kval[0] = 1'b0;
    kval[1] = 1'b0;

    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_rst_kout", d), 256'(kout[d]), 256'(0));
      check($sformatf("dut%0d_rst_busy", d), 256'(bz[d]), 256'(0));
      check($sformatf("dut%0d_rst_ready", d), 256'(rdy[d]), 256'(1));
      check($sformatf("dut%0d_rst_done", d), 256'(dn[d]), 256'(0));
    end
    @(negedge clk);
    #2 rst = 1'b0;

    send(0, 128'h2B7E151628AED2A6ABF7158809CF4F3C, -1);
    hold_two(0, ones, '0);

    // Abort dut0 while data bit 60 is on the wire.
    send(0, rnd_key(), -1);
    repeat (61) @(negedge clk);
    #2 rst = 1'b1;
    void'(exp_q[0].pop_back());
    #1;
    check("abort_kout", 256'(kout[0]), 256'(0));
    check("abort_busy", 256'(bz[0]), 256'(0));
    check("abort_ready", 256'(rdy[0]), 256'(1));
    check("abort_done", 256'(dn[0]), 256'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    send(0, rnd_key(), -1);

    send(1, 128'h1, -1);
    hold_two(1, ones, '0);

    send(0, 128'h7, -1);
    send(0, 128'h3, -1);

    for (int i = 0; i < 6; i++) begin
      int d;
      d = $urandom_range(1, 0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      send(d, rnd_key(), -1);
    end

    w = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || bz[0] || bz[1]) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("drain_dut0", 256'(exp_q[0].size()), 256'(0));
    check("drain_dut1", 256'(exp_q[1].size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
